// File: rtl/capture_pkg.sv
// Shared constants, state encoding and circular-pointer helper for the capture sequencer.
package capture_pkg;

  localparam int DEPTH = 31744;
  localparam int AW    = 15;
  localparam int DW    = 18;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    POST = 3'd2,
    DONE = 3'd3,
    READ = 3'd4
  } state_t;

  // DEPTH is not a power of two, so wrap is explicit rather than by overflow.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO holding RAM read data ahead of the readout port; head word is stable until popped.
module skid_fifo2
  import capture_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem0, mem1;
  logic         wr_idx, rd_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_idx) mem1 <= din;
        else        mem0 <= din;
        wr_idx <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = rd_idx ? mem1 : mem0;

endmodule

// File: rtl/capture_seq31.sv
// Capture sequencer: fills a circular record in the capture RAM until trigger + post count,
// then streams it oldest-first. Handshake: a word transfers on a cycle with out_valid & out_ready.
module capture_seq31
  import capture_pkg::*;
(
  input  logic          mclk,
  input  logic          rstn,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig,
  input  logic [AW-1:0] post_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          rd_start,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [2:0]    dbg_state
);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr, post_cnt, post_len_q;
  logic [AW-1:0] rd_issued, out_cnt, rec_len, rec_start;
  logic          wrapped, rd_inflight;
  logic          capturing, wr_en, pop, rd_issue, arm_go, rd_go;
  logic [1:0]    fifo_cnt;
  logic [2:0]    occ;

  assign capturing = (state == FILL) || (state == POST);
  assign wr_en     = capturing && in_valid;
  assign rec_len   = wrapped ? AW'(DEPTH) : wr_ptr;
  assign rec_start = wrapped ? wr_ptr : '0;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (out_cnt == rec_len - 1'b1);

  // Counting the same-cycle pop lets a read issue every cycle while out_ready stays high.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, rd_inflight};
  assign rd_issue = (state == READ) && (rd_issued != rec_len) &&
                    (occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (arm) state_nxt = FILL;
        FILL: if (trig) state_nxt = (post_len_q == '0) ? DONE : POST;
        POST: if (wr_en && (post_cnt + 1'b1 == post_len_q)) state_nxt = DONE;
        DONE: begin
          if (arm) state_nxt = FILL;
          else if (rd_start && (rec_len != '0)) state_nxt = READ;
        end
        READ: if (pop && out_last) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign arm_go = (state_nxt == FILL) && ((state == IDLE) || (state == DONE));
  assign rd_go  = (state_nxt == READ) && (state == DONE);

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      wrapped     <= 1'b0;
      post_cnt    <= '0;
      post_len_q  <= '0;
      rd_ptr      <= '0;
      rd_issued   <= '0;
      out_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= rd_issue && !abort;
      if (arm_go) begin
        wr_ptr     <= '0;
        wrapped    <= 1'b0;
        post_cnt   <= '0;
        post_len_q <= post_len;
      end else if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (wr_ptr == AW'(DEPTH - 1)) wrapped <= 1'b1;
        if (state == POST) post_cnt <= post_cnt + 1'b1;
      end
      if (rd_go) begin
        rd_ptr    <= rec_start;
        rd_issued <= '0;
        out_cnt   <= '0;
      end else if (state == READ) begin
        if (rd_issue) begin
          rd_ptr    <= ptr_inc(rd_ptr);
          rd_issued <= rd_issued + 1'b1;
        end
        if (pop) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  skid_fifo2 #(.W(DW)) u_fifo (
    .clk   (mclk),
    .rstn  (rstn),
    .flush (abort),
    .push  (rd_inflight),
    .din   (ram_rdata),
    .pop   (pop),
    .dout  (out_data),
    .count (fifo_cnt)
  );

  assign ram_wen   = wr_en;
  assign ram_addr  = capturing ? wr_ptr : ((state == READ) ? rd_ptr : '0);
  assign ram_wdata = capturing ? in_data : '0;
  assign busy      = capturing || (state == READ);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_capture_seq31.sv
// Randomized bench for capture_seq31 with a behavioural RAM and a record-level reference model.
module tb_capture_seq31;
  import capture_pkg::*;

  logic          mclk, rstn, arm, abort, trig, in_valid, rd_start, out_ready;
  logic [AW-1:0] post_len, ram_addr;
  logic [DW-1:0] in_data, out_data, ram_wdata, ram_rdata;
  logic          out_valid, out_last, busy, done, ram_wen;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] sample_ctr;
  logic [DW-1:0] ram_mem [DEPTH];
  bit addr_bad = 0;

  capture_seq31 dut (
    .mclk(mclk), .rstn(rstn), .arm(arm), .abort(abort), .trig(trig),
    .post_len(post_len), .in_valid(in_valid), .in_data(in_data),
    .rd_start(rd_start), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // synchronous RAM, read data one cycle after address
  always @(posedge mclk) begin
    if (int'(ram_addr) < DEPTH) begin
      if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  always @(negedge mclk) begin
    if (rstn && int'(ram_addr) >= DEPTH) addr_bad = 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Drive a capture; the model keeps every written sample and trims to the newest DEPTH.
  task automatic do_capture(input int plen, input int n_pre, input int vprob, input bit big);
    int  posted = 0;
    int  nwr = 0;
    int  cyc = 0;
    bit  trig_done = 0;
    bit  fin = 0;
    bit  early = 0;
    wr_q.delete();
    post_len = AW'(plen);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    while (!fin && cyc < 60000) begin
      if (done) early = 1;
      if (n_pre == 0) begin
        in_valid = 1'b0;
        trig     = !trig_done;
      end else begin
        in_valid = ($urandom_range(99) < vprob);
        trig     = !trig_done && in_valid && (nwr == n_pre - 1);
      end
      in_data = sample_ctr;
      if (big && nwr == DEPTH - 1) check("addr_top", 32'(ram_addr), 32'(DEPTH - 1));
      if (big && nwr == DEPTH)     check("addr_wrap", 32'(ram_addr), 32'd0);
      if (trig_done && in_valid) posted++;
      if (in_valid) begin
        wr_q.push_back(in_data);
        nwr++;
        sample_ctr++;
        if (wr_q.size() > DEPTH) void'(wr_q.pop_front());
      end
      if (trig) trig_done = 1;
      fin = trig_done && (posted >= plen);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    trig     = 1'b0;
    check("cap_early", 32'(early), 32'd0);
    check("cap_done", 32'(done), 32'd1);
    check("cap_busy", 32'(busy), 32'd0);
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic do_read(input int mode, input int first_exp, input int last_exp);
    logic [DW-1:0] e, prev_data;
    bit ready, prev_stall = 0, stall_bad = 0, seen = 0;
    int cyc = 0, idx = 0;
    int bound;
    exp_q = wr_q;
    bound = exp_q.size() * 4 + 20;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    while (exp_q.size() > 0 && cyc < bound) begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad = 1;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready = ($urandom_range(1) == 1);
      endcase
      if (out_valid && ready) begin
        e = exp_q.pop_front();
        check("rd_data", 32'(out_data), 32'(e));
        check("rd_last", 32'(out_last), 32'(exp_q.size() == 0));
        if (idx == 0 && first_exp >= 0) check("rd_first", 32'(out_data), 32'(first_exp));
        if (exp_q.size() == 0 && last_exp >= 0) check("rd_lastval", 32'(out_data), 32'(last_exp));
        idx++;
      end
      prev_stall = out_valid && !ready;
      prev_data  = out_data;
      out_ready  = ready;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    out_ready = 1'b0;
    check("rd_left", 32'(exp_q.size()), 32'd0);
    check("rd_stall", 32'(stall_bad), 32'd0);
    check("rd_extra", 32'(seen), 32'd0);
    check("rd_done", 32'(done), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; arm = 0; abort = 0; trig = 0; in_valid = 0; rd_start = 0;
    out_ready = 0; post_len = '0; in_data = '0; sample_ctr = '0;
    #22;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    step();
    rstn = 1'b1;
    step();

    // directed: post_len 4, trigger with sample 6
    sample_ctr = 18'd1;
    do_capture(4, 6, 100, 0);
    do_read(0, 1, 10);
    do_read(1, 1, 10);

    // post_len 0 with no samples: empty record
    do_capture(0, 0, 100, 0);
    do_read(2, -1, -1);
    check("empty_state", 32'(dbg_state), 32'(DONE));

    // random captures
    for (int r = 0; r < 5; r++) begin
      sample_ctr = 18'($urandom);
      do_capture($urandom_range(0, 20), $urandom_range(1, 30), $urandom_range(30, 100), 0);
      do_read(r % 3, -1, -1);
    end

    // abort during POST
    post_len = AW'(50); arm = 1'b1; step(); arm = 1'b0;
    in_valid = 1'b1; in_data = 18'h155; trig = 1'b1; step(); trig = 1'b0;
    step(); step();
    check("post_state", 32'(dbg_state), 32'(POST));
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_post_state", 32'(dbg_state), 32'(IDLE));
    check("abort_post_wen", 32'(ram_wen), 32'd0);
    check("abort_post_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rd_start = 1'b1; step(); rd_start = 1'b0;
    check("idle_rdstart", 32'(dbg_state), 32'(IDLE));

    // abort during READ with the FIFO holding data
    sample_ctr = 18'd500;
    do_capture(3, 5, 100, 0);
    rd_start = 1'b1; step(); rd_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_head", 32'(out_data), 32'd500);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_rd_state", 32'(dbg_state), 32'(IDLE));
    check("abort_rd_valid", 32'(out_valid), 32'd0);

    // async reset mid-READ
    do_capture(2, 3, 100, 0);
    rd_start = 1'b1; step(); rd_start = 1'b0;
    step(); step();
    in_valid = 1'b1; in_data = 18'h3ffff;
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wdata", 32'(ram_wdata), 32'd0);
    check("arst_addr", 32'(ram_addr), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    in_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // wrapped capture: 39100 samples stored, newest DEPTH read back
    sample_ctr = 18'd1;
    do_capture(100, 39000, 100, 1);
    do_read(0, 39100 - DEPTH + 1, 39100);

    check("addr_range", 32'(addr_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
